// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default sizing for the VC datapath, the
// link-scheduler state encoding and the VC index type used by arbiters and buffers.
package noc_pkg;

  localparam int DEF_NUM_VC       = 4;
  localparam int DEF_CREDIT_DEPTH = 4;
  localparam int DEF_VCW          = $clog2(DEF_NUM_VC);
  localparam int DEF_CW           = $clog2(DEF_CREDIT_DEPTH + 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  typedef logic [DEF_VCW-1:0] vc_idx_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set req bit scanning
// ptr+1, ptr+2, ... wraps modulo NUM_VC, so ptr itself has the lowest priority.
module rr_pick #(
  parameter int NUM_VC = 4,
  parameter int VCW    = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VCW-1:0]    ptr,
  output logic              any,
  output logic [VCW-1:0]    idx
);

  logic [VCW-1:0] cand;

  // Scan from the lowest priority up so the highest-priority hit is written last.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    for (int i = NUM_VC; i >= 1; i--) begin
      cand = ptr + VCW'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/vc_link_scheduler.sv
// Output-link scheduler: wormhole-locked, round-robin sharing of one link among
// NUM_VC virtual channels, gated by per-VC downstream credit counters.
module vc_link_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_VC       = DEF_NUM_VC,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int VCW          = $clog2(NUM_VC),
  parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_VC-1:0] vc_req,
  input  logic [NUM_VC-1:0] vc_tail,
  input  logic              link_ready,
  input  logic              credit_ret,
  input  logic [VCW-1:0]    credit_ret_vc,
  output logic [NUM_VC-1:0] pop,
  output logic              out_valid,
  output logic [VCW-1:0]    out_vc,
  output logic              locked,
  output logic              credit_err
);

  state_t            state;
  logic [VCW-1:0]    lock_vc;
  logic [VCW-1:0]    rr_ptr;
  logic [NUM_VC-1:0] eligible;
  logic [NUM_VC-1:0] overflow;
  logic              win_any;
  logic [VCW-1:0]    win_idx;
  logic              pop_any;
  logic [VCW-1:0]    pop_vc;

  rr_pick #(
    .NUM_VC(NUM_VC),
    .VCW   (VCW)
  ) u_pick (
    .req(eligible),
    .ptr(rr_ptr),
    .any(win_any),
    .idx(win_idx)
  );

  // While locked only the owning VC may send; pop is held low during reset.
  always_comb begin
    pop     = '0;
    pop_any = 1'b0;
    pop_vc  = lock_vc;
    if (rst && link_ready) begin
      if (state == IDLE) begin
        if (win_any) begin
          pop_any = 1'b1;
          pop_vc  = win_idx;
        end
      end else if (eligible[lock_vc]) begin
        pop_any = 1'b1;
        pop_vc  = lock_vc;
      end
    end
    if (pop_any) pop[pop_vc] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lock_vc   <= '0;
      rr_ptr    <= VCW'(NUM_VC - 1);
      out_valid <= 1'b0;
      out_vc    <= '0;
      locked    <= 1'b0;
    end else begin
      out_valid <= pop_any;
      if (pop_any) out_vc <= pop_vc;
      case (state)
        IDLE: begin
          if (pop_any) begin
            rr_ptr <= pop_vc;
            if (!vc_tail[pop_vc]) begin
              state   <= LOCK;
              lock_vc <= pop_vc;
              locked  <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (pop_any && vc_tail[pop_vc]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
      endcase
    end
  end

  // A same-cycle pop and return cancel; a return into a full counter is dropped.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
    logic [CW-1:0] cnt;
    logic          ret_hit;

    assign ret_hit     = credit_ret && (credit_ret_vc == VCW'(v));
    assign overflow[v] = ret_hit && !pop[v] && (cnt == CW'(CREDIT_DEPTH));
    assign eligible[v] = vc_req[v] && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= CW'(CREDIT_DEPTH);
      end else if (ret_hit && !pop[v] && !overflow[v]) begin
        cnt <= cnt + CW'(1);
      end else if (pop[v] && !ret_hit) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) credit_err <= 1'b0;
    else if (|overflow) credit_err <= 1'b1;
  end

endmodule

// File: doc/vc_link_scheduler.md
# vc_link_scheduler

Output-link scheduler for one router output port. It shares the physical link among NUM_VC virtual-channel buffers using wormhole packet locking and round-robin arbitration between packets. It tracks per-VC downstream credits, so a flit is only launched when the downstream VC buffer has space. It sits between the per-VC input buffers (driving their pop strobes) and the output link register/mux.

## Interface
Parameters:
- NUM_VC, 4, number of virtual channels (power of two, 2..8)
- CREDIT_DEPTH, 4, downstream buffer depth per VC; credit counter reset value
- VCW, $clog2(NUM_VC), VC index width
- CW, $clog2(CREDIT_DEPTH+1), credit counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- vc_req  in  NUM_VC  per-VC buffer not-empty
- vc_tail  in  NUM_VC  per-VC head-of-buffer flit is a tail flit (single-flit packet = head+tail)
- link_ready  in  1  output link can accept a flit this cycle
- credit_ret  in  1  downstream returns one credit
- credit_ret_vc  in  VCW  VC of returned credit
- pop  out  NUM_VC  one-hot/zero; combinational dequeue strobe to VC buffers
- out_valid  out  1  registered; flit on link this cycle
- out_vc  out  VCW  registered; VC tag of launched flit
- locked  out  1  registered; a packet currently owns the link
- credit_err  out  1  registered, sticky; credit overflow detected

## Operation
- eligible[v] = vc_req[v] && credit[v] != 0.
- FSM states: IDLE, LOCK. Register lock_vc (VCW) and rr_ptr (VCW, last-granted VC).
- IDLE: if link_ready and any eligible, the winner is the first eligible VC scanning rr_ptr+1, rr_ptr+2, … (modulo NUM_VC). Assert pop[winner] in the same cycle and set rr_ptr <= winner.
  - If vc_tail[winner] is set, stay in IDLE (single-flit packet).
  - Otherwise go to LOCK with lock_vc <= winner.
- LOCK: only lock_vc may send. If link_ready and eligible[lock_vc], assert pop[lock_vc]. If vc_tail[lock_vc] is set on that transfer, go to IDLE.
  - Otherwise hold LOCK. Stall with no pop if the buffer is empty, credits are zero, or link_ready is low.
  - Other VCs are never granted while locked, even if eligible.
- At most one pop bit per cycle. No pop when link_ready=0.
- Credits: on each pop[v], credit[v] decrements by 1. On credit_ret, credit[credit_ret_vc] increments by 1.
  - Pop and return to the same VC in the same cycle leaves the counter unchanged.
  - A return to a counter already at CREDIT_DEPTH (with no same-cycle pop) is dropped and sets credit_err (cleared only by reset).
- A credit returned in cycle N makes that VC eligible in cycle N+1; credits are not bypassed.

## Timing
- pop is combinational from vc_req, vc_tail, link_ready and registered state (no path from credit_ret).
- out_valid/out_vc register the pop cycle. They are valid exactly 1 cycle after pop, aligned with registered buffer read data.
- Back-to-back: one flit per cycle sustained while link_ready=1 and credits > 0.
- Packet boundary: the tail pop and a new packet's head pop are never in the same cycle. The next head is granted earliest the cycle after the tail. IDLE single-flit packets may issue every cycle, rotating.
- Reset values: state=IDLE, rr_ptr=NUM_VC-1 (VC0 first priority), lock_vc=0, credit[*]=CREDIT_DEPTH, pop=0, out_valid=0, out_vc=0, locked=0, credit_err=0.
- Reset asserted mid-packet aborts the lock immediately and restores full credits; downstream is reset together with the router.

## Structure
- Shared package noc_pkg:
  - NUM_VC, CREDIT_DEPTH, VCW and CW defaults
  - state enum {IDLE, LOCK}
  - VC index typedef, shared with the existing VC arbiter and buffers
- One sub-module: rr_pick, a combinational rotating-priority picker with inputs req[NUM_VC] and ptr[VCW], and outputs any and idx[VCW].
- Credit counters are a generate loop inside vc_link_scheduler.

## Test plan
- Reset, then all four VCs with single-flit packets, link_ready=1: pop sequence VC0,1,2,3,0…; out_vc follows one cycle later; each credit reaches 0 after 4 pops; with no returns, pops stop.
- VC1 3-flit packet (tail on flit 3) while VC2 also requests: pop[1] for 3 consecutive cycles, locked=1, VC2 blocked; VC2 is granted the cycle after the tail.
- Locked on VC0 with credit[0]=0 mid-packet: no pop, stays locked. Return a credit for VC0 at cycle N: pop[0] at N+1.
- link_ready toggling 1,0,1 during a packet: pops only in ready cycles; no grant change.
- Simultaneous pop and credit_ret on VC3: credit[3] unchanged. A return to full VC2: credit_err=1, and it stays set until reset.
- Assert rst mid-packet on VC1: all outputs go to 0 asynchronously, credits return to CREDIT_DEPTH, and VC0 wins first after release.
